// File: rtl/sspwm_pkg.sv
// Shared constants and FSM state type for the single-pulse sine PWM phase sequencer.
package sspwm_pkg;

  localparam int unsigned PHASE_W       = 8;
  localparam int unsigned CARR_W        = 12;
  localparam int unsigned PHASE_MAX_DEF = 40;
  localparam int unsigned CARR_MIN      = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/sspwm_deadtime.sv
// Complementary gate generator: any change of the raw compare drops both gates
// for DEAD_TIME clocks before the new level is driven.
module sspwm_deadtime #(
  parameter int unsigned DEAD_TIME = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam int unsigned CNT_W = $clog2(DEAD_TIME + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_raw_prev;
  logic             r_armed;
  logic             r_hi;
  logic             r_lo;

  // The first active cycle counts as a raw change, so entry starts a dead gap.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      r_cnt      <= '0;
      r_raw_prev <= 1'b0;
      r_armed    <= 1'b0;
      r_hi       <= 1'b0;
      r_lo       <= 1'b0;
    end else if (!r_armed || (raw != r_raw_prev)) begin
      r_armed    <= 1'b1;
      r_raw_prev <= raw;
      r_cnt      <= CNT_W'(DEAD_TIME);
      r_hi       <= 1'b0;
      r_lo       <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_hi <= r_raw_prev;
        r_lo <= !r_raw_prev;
      end
    end
  end

  assign pwm_hi = r_hi;
  assign pwm_lo = r_lo;

endmodule

// File: rtl/sspwm_phase_ctrl.sv
// Steps the sine LUT phase once per triangle-carrier period, registers the LUT
// sample and compares it with the carrier to drive dead-time protected gates.
module sspwm_phase_ctrl #(
  parameter int unsigned PHASE_MAX = sspwm_pkg::PHASE_MAX_DEF,
  parameter int unsigned DEAD_TIME = 8,
  parameter int unsigned CARR_W    = sspwm_pkg::CARR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [CARR_W-1:0]             carrier_top,
  output logic [sspwm_pkg::PHASE_W-1:0] teth_ta,
  input  logic [CARR_W-1:0]             sine_in,
  output logic                          pwm_hi,
  output logic                          pwm_lo,
  output logic                          period_done,
  output logic                          busy
);
  import sspwm_pkg::*;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CARR_W-1:0]   r_carrier;
  logic [CARR_W-1:0]   r_top_sh;
  logic [CARR_W-1:0]   r_sample;
  logic [CARR_W-1:0]   w_top_clamped;
  logic [PHASE_W-1:0]  r_phase;
  logic                r_dir_down;
  logic                r_valley_d;
  logic                r_period_done;
  logic                w_valley;
  logic                w_wrap;
  logic                w_raw;
  logic                w_active_nxt;

  assign w_top_clamped = (carrier_top < CARR_W'(CARR_MIN)) ? CARR_W'(CARR_MIN) : carrier_top;
  assign w_valley      = (r_state != IDLE) && r_dir_down && (r_carrier == CARR_W'(1));
  assign w_wrap        = w_valley && (r_phase == PHASE_W'(PHASE_MAX));
  assign w_raw         = r_sample > r_carrier;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (en) w_state_nxt = RUN;
      RUN:      if (!en) w_state_nxt = STOPPING;
      STOPPING: begin
        if (en)          w_state_nxt = RUN;
        else if (w_wrap) w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
    if (rst) w_state_nxt = IDLE;
  end

  assign w_active_nxt = (w_state_nxt != IDLE);

  // Idle and the RUN-entry edge share one branch: both leave the datapath at its
  // reset values (carrier 0 counting up, fresh top_sh, sample 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_carrier     <= '0;
      r_dir_down    <= 1'b0;
      r_top_sh      <= w_top_clamped;
      r_phase       <= '0;
      r_sample      <= '0;
      r_valley_d    <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_period_done <= w_wrap;
      if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
        r_carrier  <= '0;
        r_dir_down <= 1'b0;
        r_top_sh   <= w_top_clamped;
        r_phase    <= '0;
        r_sample   <= '0;
        r_valley_d <= 1'b0;
      end else begin
        r_valley_d <= w_valley;
        if (r_valley_d) r_sample <= sine_in;
        if (w_valley) begin
          r_carrier  <= '0;
          r_dir_down <= 1'b0;
          r_top_sh   <= w_top_clamped;
          r_phase    <= (r_phase == PHASE_W'(PHASE_MAX)) ? '0 : r_phase + PHASE_W'(1);
        end else if (!r_dir_down) begin
          if (r_carrier >= r_top_sh) begin
            r_carrier  <= r_carrier - CARR_W'(1);
            r_dir_down <= 1'b1;
          end else begin
            r_carrier <= r_carrier + CARR_W'(1);
          end
        end else begin
          r_carrier <= r_carrier - CARR_W'(1);
        end
      end
    end
  end

  sspwm_deadtime #(
    .DEAD_TIME (DEAD_TIME)
  ) u_deadtime (
    .clk    (clk),
    .rst    (rst),
    .active (w_active_nxt),
    .raw    (w_raw),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

  assign teth_ta     = r_phase;
  assign period_done = r_period_done;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_sspwm_phase_ctrl.sv
// Scoreboard bench for sspwm_phase_ctrl: a cycle model queues expected outputs
// at each clock edge; a negedge monitor pops and compares them.
module tb_sspwm_phase_ctrl;

  localparam int PHASE_MAX = 40;
  localparam int DEAD      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [11:0] carrier_top = 12'd4;
  logic [11:0] sine_in;
  logic [7:0]  teth_ta;
  logic        pwm_hi, pwm_lo, period_done, busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  sspwm_phase_ctrl #(
    .PHASE_MAX (PHASE_MAX),
    .DEAD_TIME (DEAD),
    .CARR_W    (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .carrier_top (carrier_top),
    .teth_ta     (teth_ta),
    .sine_in     (sine_in),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .period_done (period_done),
    .busy        (busy)
  );

  // Test LUT: zero for indices 0..20, peak 3711 at index 30.
  function automatic logic [11:0] lut(input int i);
    int d;
    if (i <= 20) return 12'd0;
    d = (i > 30) ? i - 30 : 30 - i;
    return 12'(3711 - d * 300);
  endfunction

  function automatic int clampt(input int t);
    return (t < 2) ? 2 : t;
  endfunction

  assign sine_in = lut(int'(teth_ta));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: carrier described by position within its 2*top period,
  // dead time by the age of the last raw change.
  int m_st = 0, m_pos = 0, m_top = 2, m_ph = 0, m_samp = 0, m_age = 0;
  bit m_vd = 0, m_pd = 0, m_rawp = 0, m_hi = 0, m_lo = 0, m_was = 0;

  always @(posedge clk) begin : model
    int carr, nst;
    bit raw_b, valley, wrap;
    carr   = (m_pos <= m_top) ? m_pos : 2 * m_top - m_pos;
    raw_b  = (m_st != 0) && (m_samp > carr);
    valley = (m_st != 0) && (m_pos == 2 * m_top - 1);
    wrap   = valley && (m_ph == PHASE_MAX);
    if (rst) nst = 0;
    else case (m_st)
      0:       nst = en ? 1 : 0;
      1:       nst = en ? 1 : 2;
      default: nst = en ? 1 : (wrap ? 0 : 2);
    endcase
    if (rst || nst == 0 || m_st == 0) begin
      m_pos = 0; m_top = clampt(int'(carrier_top)); m_ph = 0; m_samp = 0; m_vd = 0;
    end else begin
      if (m_vd) m_samp = int'(lut(m_ph));
      m_vd = valley;
      if (valley) begin
        m_pos = 0;
        m_top = clampt(int'(carrier_top));
        m_ph  = (m_ph == PHASE_MAX) ? 0 : m_ph + 1;
      end else begin
        m_pos++;
      end
    end
    m_pd = !rst && wrap;
    if (nst == 0) begin
      m_rawp = 0; m_age = 0; m_hi = 0; m_lo = 0; m_was = 0;
    end else if (!m_was || raw_b != m_rawp) begin
      m_rawp = raw_b; m_age = 0; m_hi = 0; m_lo = 0; m_was = 1;
    end else begin
      if (m_age < DEAD) m_age++;
      if (m_age >= DEAD) begin m_hi = m_rawp; m_lo = !m_rawp; end
    end
    m_st = nst;
    exp_q.push_back({8'(m_ph), m_hi, m_lo, m_pd, (m_st != 0)});
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("outs{teth,hi,lo,pd,busy}", {teth_ta, pwm_hi, pwm_lo, period_done, busy}, e);
      check_eq("gate_overlap", pwm_hi & pwm_lo, 0);
    end
  end

  task automatic wait_teth(input int v, input int limit);
    int n;
    n = 0;
    while (int'(teth_ta) != v && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_teth", teth_ta, v);
  endtask

  task automatic wait_pd(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_done && n < limit);
    check_eq("pd_seen", period_done, 1);
  endtask

  task automatic wait_teth_change(input int limit, output int n);
    logic [7:0] prev;
    prev = teth_ta;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (teth_ta == prev && n < limit);
  endtask

  initial begin
    #(600_000);
    $display("FAIL watchdog: got no completion, required finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cnt, run, runs;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_teth", teth_ta, 0);
    check_eq("rst_gates", {pwm_hi, pwm_lo}, 0);
    check_eq("rst_pd", period_done, 0);

    // Entry and initial dead gap
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    check_eq("entry_busy", busy, 1);
    n = 0;
    while (!pwm_lo && n < 20) begin @(negedge clk); n++; end
    check_eq("entry_dead_gap", n, DEAD);

    // Zero-sample region: high side never asserted
    cnt = 0; n = 0;
    while (teth_ta != 8'd21 && n < 300) begin
      if (pwm_hi) cnt++;
      @(negedge clk); n++;
    end
    check_eq("reach_21", teth_ta, 21);
    check_eq("zero_region_hi", cnt, 0);

    // Phase cadence and wrap
    wait_teth_change(50, n);
    check_eq("step_top4", n, 8);
    wait_teth(40, 400);
    wait_pd(50, n);
    check_eq("wrap_after_40", n, 8);
    check_eq("wrap_to_0", teth_ta, 0);
    @(negedge clk);
    check_eq("pd_single", period_done, 0);
    wait_pd(400, n);
    check_eq("pd_interval", n + 1, 328);

    // Mid-run reset, then re-entry with en held
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_teth", teth_ta, 0);
    check_eq("midrst_gates", {pwm_hi, pwm_lo}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reentry_busy", busy, 1);

    // Peak sample with full-range carrier
    wait_teth(29, 400);
    carrier_top = 12'd4095;
    wait_teth(30, 20);
    carrier_top = 12'd4;
    run = 0; runs = 0; n = 0;
    while (teth_ta == 8'd30 && n < 9000) begin
      if (!pwm_hi && !pwm_lo) run++;
      else if (run > 0) begin
        check_eq("peak_dead_run", run, DEAD);
        runs++;
        run = 0;
      end
      @(negedge clk); n++;
    end
    check_eq("peak_dead_runs", runs, 2);

    // Stop requested then withdrawn: no gap
    wait_teth(12, 400);
    en = 1'b0;
    @(negedge clk);
    check_eq("stopping_busy", busy, 1);
    cnt = 0; n = 0;
    while (teth_ta != 8'd26 && n < 300) begin
      if (teth_ta == 8'd25) en = 1'b1;
      if (!busy) cnt++;
      @(negedge clk); n++;
    end
    check_eq("reach_26", teth_ta, 26);
    check_eq("resume_no_gap", cnt, 0);
    wait_teth_change(50, n);
    check_eq("resume_step", n, 8);

    // Graceful stop to IDLE at wrap
    wait_teth(12, 400);
    en = 1'b0;
    wait_pd(400, n);
    check_eq("stop_teth", teth_ta, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_gates", {pwm_hi, pwm_lo}, 0);
    @(negedge clk);
    check_eq("stop_pd_single", period_done, 0);
    repeat (5) @(negedge clk);
    check_eq("stays_idle", busy, 0);

    // Carrier top shadowing and clamp
    carrier_top = 12'd100; en = 1'b1;
    wait_teth_change(300, n);
    check_eq("first_step_100", n, 201);
    repeat (30) @(negedge clk);
    carrier_top = 12'd50;
    wait_teth_change(300, n);
    check_eq("peak_100", n + 30, 200);
    carrier_top = 12'd1;
    wait_teth_change(300, n);
    check_eq("peak_50", n, 100);
    wait_teth_change(50, n);
    check_eq("clamp_min", n, 4);
    wait_teth_change(50, n);
    check_eq("clamp_min2", n, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
